// File: rtl/alu_pkg.sv
// Shared ALU control codes, op classes and the issue bundle.
// Imported by the issue stage and the control decoder.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  typedef struct packed {
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
    logic [3:0]          control;
    logic                illegal;
  } issue_t;

  localparam issue_t ISSUE_RST = '{
    a:       '0,
    b:       '0,
    control: ALU_ADD,
    illegal: 1'b0
  };

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_op/funct3/funct7[5] to 4-bit ALU control.
// Unsupported ops map to ALU_ILL and raise illegal.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [3:0] o_control,
  output logic       o_illegal
);

  logic w_sub;

  // Only R-type honours bit 30; I-type ADDI has no SUB form.
  assign w_sub = (i_alu_op == ALUOP_R) && i_funct7_5;

  // Decode table: fixed ops first, then funct3 for R/I.
  always_comb begin
    o_control = ALU_ILL;
    unique case (i_alu_op)
      ALUOP_MEM: o_control = ALU_ADD;
      ALUOP_BR:  o_control = ALU_SUB;
      default: begin
        unique case (i_funct3)
          3'b000:  o_control = w_sub ? ALU_SUB : ALU_ADD;
          3'b111:  o_control = ALU_AND;
          3'b110:  o_control = ALU_OR;
          default: o_control = ALU_ILL;
        endcase
      end
    endcase
  end

  assign o_illegal = (o_control == ALU_ILL);

endmodule

// File: rtl/alu_issue_stage.sv
// Execute issue register with 2-entry skid buffer.
// M drives the ALU inputs, S absorbs one op on stall.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  imm,
  input  logic             use_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count
);

  issue_t           r_m;
  issue_t           r_s;
  logic             r_m_valid;
  logic             r_s_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  issue_t w_in;
  issue_t w_m_nx;
  issue_t w_s_nx;
  logic   w_m_valid_nx;
  logic   w_s_valid_nx;
  logic   w_acc;
  logic   w_xfer;
  logic   w_ctrl_ill;
  logic [3:0] w_ctrl;

  alu_ctrl_decode u_dec (
    .i_alu_op   (alu_op),
    .i_funct3   (funct3),
    .i_funct7_5 (funct7_5),
    .o_control  (w_ctrl),
    .o_illegal  (w_ctrl_ill)
  );

  assign w_in.a       = rs1_val;
  assign w_in.b       = use_imm ? imm : rs2_val;
  assign w_in.control = w_ctrl;
  assign w_in.illegal = w_ctrl_ill;

  assign w_acc  = in_valid & r_in_ready;
  assign w_xfer = r_m_valid & out_ready;

  // Next M/S: refill M from S first so order is kept.
  always_comb begin
    w_m_nx       = r_m;
    w_s_nx       = r_s;
    w_m_valid_nx = r_m_valid;
    w_s_valid_nx = r_s_valid;
    if (!r_m_valid || w_xfer) begin
      if (r_s_valid) begin
        w_m_nx       = r_s;
        w_m_valid_nx = 1'b1;
        w_s_valid_nx = 1'b0;
      end else if (w_acc) begin
        w_m_nx       = w_in;
        w_m_valid_nx = 1'b1;
      end else begin
        w_m_valid_nx = 1'b0;
      end
    end else if (w_acc) begin
      w_s_nx       = w_in;
      w_s_valid_nx = 1'b1;
    end
    if (flush) begin
      w_m_valid_nx = 1'b0;
      w_s_valid_nx = 1'b0;
    end
  end

  // Buffer state, registered ready and hand-off counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m        <= ISSUE_RST;
      r_s        <= ISSUE_RST;
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
      r_cnt      <= '0;
    end else begin
      r_m        <= w_m_nx;
      r_s        <= w_s_nx;
      r_m_valid  <= w_m_valid_nx;
      r_s_valid  <= w_s_valid_nx;
      r_in_ready <= !w_s_valid_nx;
      if (w_xfer) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_m_valid;
  assign alu_a       = r_m.a;
  assign alu_b       = r_m.b;
  assign alu_control = r_m.control;
  assign illegal     = r_m.illegal;
  assign issue_count = r_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: queue scoreboard vs
// a capacity-2 FIFO model of the issue stage.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5, use_imm;
  logic [31:0] rs1_val, rs2_val, imm;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic        illegal;
  logic [3:0]  issue_count;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic [3:0] m_cnt = '0;
  bit   chk_rst = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .imm         (imm),
    .use_imm     (use_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .illegal     (illegal),
    .issue_count (issue_count)
  );

  task automatic check(input string nm,
                       input logic [68:0] got,
                       input logic [68:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Reference: ALU control from the op table.
  function automatic exp_t model(input logic [1:0] op,
                                 input logic [2:0] f3,
                                 input logic f7,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [31:0] im,
                                 input logic ui);
    exp_t e;
    e.a = a;
    e.b = ui ? im : b;
    if (op == 2'd0)        e.c = 4'h2;
    else if (op == 2'd1)   e.c = 4'h6;
    else if (f3 == 3'd0)   e.c = (op == 2'd2 && f7) ? 4'h6 : 4'h2;
    else if (f3 == 3'd7)   e.c = 4'h0;
    else if (f3 == 3'd6)   e.c = 4'h1;
    else                   e.c = 4'hF;
    e.ill = (e.c == 4'hF);
    return e;
  endfunction

  // Monitor: inputs and outputs are stable at negedge.
  always @(negedge clk) begin
    exp_t e, g;
    if (chk_rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_control", alu_control, 4'h2);
      check("rst_illegal", illegal, 0);
      check("rst_count", issue_count, 0);
    end
    chk_rst = rst;
    if (rst) begin
      q.delete();
      m_cnt = '0;
    end else begin
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, q.size() < 2);
      check("issue_count", issue_count, m_cnt);
      if (out_valid && out_ready) begin
        g = '{alu_a, alu_b, alu_control, illegal};
        if (q.size() == 0) begin
          check("spurious_op", g, 0 - 1);
        end else begin
          e = q.pop_front();
          check("op", g, e);
        end
        m_cnt = m_cnt + 4'd1;
      end
      if (flush) q.delete();
      else if (in_valid && in_ready)
        q.push_back(model(alu_op, funct3, funct7_5,
                          rs1_val, rs2_val, imm, use_imm));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op,
                        input logic [2:0] f3,
                        input logic f7,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] im,
                        input logic ui);
    alu_op = op; funct3 = f3; funct7_5 = f7;
    rs1_val = a; rs2_val = b; imm = im; use_imm = ui;
  endtask

  // Hold in_valid until accepted, bounded.
  task automatic send(input logic [1:0] op,
                      input logic [2:0] f3,
                      input logic f7,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] im,
                      input logic ui);
    bit ok = 0;
    set_op(op, f3, f7, a, b, im, ui);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 0;
    out_ready = 1;
    tick();

    send(2'd2, 3'd0, 1, 32'd10, 32'd3, 32'd0, 0);
    send(2'd3, 3'd7, 0, 32'h1234, 32'd5, 32'hFFFFFFFF, 1);
    send(2'd2, 3'd1, 0, 32'd7, 32'd8, 32'd0, 0);
    send(2'd3, 3'd0, 1, 32'd1, 32'd2, 32'd9, 1);
    send(2'd0, 3'd5, 1, 32'd4, 32'd6, 32'd0, 0);
    send(2'd1, 3'd2, 0, 32'd9, 32'd9, 32'd0, 0);
    tick();

    out_ready = 0;
    send(2'd2, 3'd6, 0, 32'hA0, 32'hB0, 0, 0);
    send(2'd2, 3'd7, 0, 32'hA1, 32'hB1, 0, 0);
    fork
      send(2'd3, 3'd6, 0, 32'hA2, 32'hB2, 32'hC2, 1);
      begin
        tick(); tick(); tick();
        out_ready = 1;
      end
    join
    tick(); tick(); tick();

    out_ready = 0;
    send(2'd0, 0, 0, 32'h11, 32'h22, 0, 0);
    set_op(2'd1, 0, 0, 32'h33, 32'h44, 0, 0);
    in_valid = 1; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    tick();

    send(2'd0, 0, 0, 32'h55, 32'h66, 0, 0);
    send(2'd0, 0, 0, 32'h77, 32'h88, 0, 0);
    set_op(2'd1, 0, 0, 32'h99, 32'hAA, 0, 0);
    in_valid = 1; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    tick();

    rst = 1; tick(); rst = 0;
    out_ready = 1;
    for (int i = 0; i < 17; i++)
      send(2'd3, 3'd0, 0, i, 0, i + 100, 1);
    tick(); tick();
    @(negedge clk);
    check("cnt17_wrap", issue_count, 4'd1);
    tick();

    out_ready = 0;
    send(2'd2, 3'd0, 0, 32'h5, 32'h6, 0, 0);
    send(2'd2, 3'd0, 1, 32'h7, 32'h8, 0, 0);
    rst = 1; tick(); rst = 0;
    tick(); tick();

    for (int i = 0; i < 400; i++) begin
      set_op($urandom_range(0, 3), $urandom_range(0, 7),
             1'($urandom), $urandom, $urandom, $urandom,
             1'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 30) == 0);
      rst       = ($urandom_range(0, 150) == 0);
      tick();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    repeat (5) tick();
    @(negedge clk);
    check("drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
